// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-detects raw exception sources, arbitrates among
// them by fixed priority with strict nesting, and tracks return addresses
// on an EPC stack. has_exp and is_eret are registered redirect pulses, and
// target_pc carries the redirect PC.
module interrupt_arbiter #(
  parameter int              NSRC     = 3,
  parameter logic [31:0]     VEC_BASE = 32'h0000_0800,
  parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}},
  localparam int             CW       = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int             SPW      = $clog2(NSRC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_in,
  input  logic [31:0]     pc_in,
  input  logic            stall,
  input  logic            eret,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  output logic            has_exp,
  output logic            is_eret,
  output logic [31:0]     target_pc,
  output logic [CW-1:0]   cause,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] overrun
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] event_v;
  logic [NSRC-1:0] nest_ok;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] grant_oh;
  logic [NSRC-1:0] lowest_is;
  logic            grant_any;
  logic [CW-1:0]   grant_idx;
  logic [31:0]     grant_vec;
  logic            eret_ok;

  // Return-address stack. Nesting only ever admits a strictly higher
  // priority source, so at most NSRC entries can be live at once.
  logic [31:0]     epc_stack [NSRC];
  logic [SPW-1:0]  sp;
  logic [SPW-1:0]  sp_m1;

  // Rising-edge events on the raw source levels.
  assign event_v = src_in & ~src_q;

  // Return is accepted only while something is in service; it then owns
  // the cycle and blocks any new grant.
  assign eret_ok = eret && (in_service != '0);

  // Isolate the lowest-index in_service bit (the innermost handler).
  assign lowest_is = in_service & (~in_service + 1'b1);

  assign sp_m1 = sp - 1'b1;

  // Nesting filter, eligibility and fixed-priority selection.
  always_comb begin
    logic seen;
    logic found;
    // NOTE: every variable gets a default before any branch so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    seen      = 1'b0;
    found     = 1'b0;
    nest_ok   = '0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      // A source may preempt only if no equal-or-higher priority source
      // is already in service.
      seen       = seen | in_service[i];
      nest_ok[i] = ~seen;
    end
    eligible = pending & mask & nest_ok & {NSRC{~stall & ~eret}};
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && !found) begin
        found       = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = CW'(i);
      end
    end
    grant_any = found;
    grant_vec = VEC_BASE + (32'(grant_idx) << 4);
  end

  // Edge-detect register, pending latch and sticky overrun flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      src_q   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      src_q   <= src_in;
      // A new event on the granting edge re-arms pending without overrun.
      pending <= (pending & ~grant_oh) | event_v;
      overrun <= overrun | (event_v & pending & ~grant_oh);
    end
  end

  // Enable mask; a write is seen by arbitration from the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_wd;
    end
  end

  // Nesting state: in_service bits and the EPC stack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_service <= '0;
      sp         <= '0;
      // NOTE: the stack contents are cleared explicitly on reset so a
      // return after reset can never expose stale addresses; this makes
      // the array flops rather than a RAM, which is fine at this depth.
      for (int i = 0; i < NSRC; i++) begin
        epc_stack[i] <= '0;
      end
    end else if (eret_ok) begin
      in_service <= in_service & ~lowest_is;
      sp         <= sp_m1;
    end else if (grant_any) begin
      in_service                 <= in_service | grant_oh;
      epc_stack[sp[CW-1:0]]      <= pc_in;
      sp                         <= sp + 1'b1;
    end
  end

  // Registered redirect pulses, target PC and cause.
  always_ff @(posedge clk) begin
    if (!rst) begin
      has_exp   <= 1'b0;
      is_eret   <= 1'b0;
      target_pc <= '0;
      cause     <= '0;
    end else begin
      has_exp <= grant_any;
      is_eret <= eret_ok;
      if (eret_ok) begin
        target_pc <= epc_stack[sp_m1[CW-1:0]];
      end else if (grant_any) begin
        target_pc <= grant_vec;
        cause     <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter (NSRC=3, VEC_BASE=0x800).
// Every redirect the stimulus should cause is queued when driven; a
// negedge monitor pops and compares each has_exp / is_eret pulse.
module tb_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        eret;
  logic        mask_we;
  logic [2:0]  mask_wd;
  logic        has_exp;
  logic        is_eret;
  logic [31:0] target_pc;
  logic [1:0]  cause;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [2:0]  mask;
  logic [2:0]  overrun;

  interrupt_arbiter #(
    .NSRC     (3),
    .VEC_BASE (32'h0000_0800),
    .MASK_RST (3'b111)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in),
    .pc_in      (pc_in),
    .stall      (stall),
    .eret       (eret),
    .mask_we    (mask_we),
    .mask_wd    (mask_wd),
    .has_exp    (has_exp),
    .is_eret    (is_eret),
    .target_pc  (target_pc),
    .cause      (cause),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_ret;
    logic [31:0] pc;
    logic [1:0]  cause;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  both_hi  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_st(input string tag, input logic [2:0] exp_pend, input logic [2:0] exp_is);
    check({tag, "_pending"}, 32'(pending), 32'(exp_pend));
    check({tag, "_in_service"}, 32'(in_service), 32'(exp_is));
  endtask

  task automatic expect_exp(input logic [31:0] pc, input logic [1:0] c);
    sb_t e;
    e.is_ret = 1'b0;
    e.pc     = pc;
    e.cause  = c;
    sb.push_back(e);
  endtask

  task automatic expect_ret(input logic [31:0] pc, input logic [1:0] c);
    sb_t e;
    e.is_ret = 1'b1;
    e.pc     = pc;
    e.cause  = c;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued redirect.
  always @(negedge clk) begin
    if (has_exp && is_eret) both_hi++;
    if (has_exp || is_eret) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({has_exp, is_eret}), 32'(2'b00));
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({has_exp, is_eret}), 32'(e.is_ret ? 2'b01 : 2'b10));
        check("target_pc", target_pc, e.pc);
        check("cause", 32'(cause), 32'(e.cause));
      end
    end
  end

  initial begin
    rst     = 1'b0;
    src_in  = '0;
    pc_in   = '0;
    stall   = 1'b0;
    eret    = 1'b0;
    mask_we = 1'b0;
    mask_wd = '0;
    step(2);
    check_st("rst", 3'b000, 3'b000);
    check("rst_overrun", 32'(overrun), 32'(3'b000));
    check("rst_mask", 32'(mask), 32'(3'b111));
    check("rst_pulses", 32'({has_exp, is_eret}), 32'(2'b00));
    check("rst_target", target_pc, 32'h0);
    rst = 1'b1;
    step(1);

    // Single event: two-edge latency, then return.
    pc_in     = 32'h100;
    src_in[1] = 1'b1;
    expect_exp(32'h810, 2'd1);
    step(1);
    check_st("single_e1", 3'b010, 3'b000);
    check("single_e1_has_exp", 32'(has_exp), 32'(1'b0));
    step(1);
    check("single_e2_has_exp", 32'(has_exp), 32'(1'b1));
    check_st("single_grant", 3'b000, 3'b010);
    src_in[1] = 1'b0;
    eret      = 1'b1;
    expect_ret(32'h100, 2'd1);
    step(1);
    check("single_is_eret", 32'(is_eret), 32'(1'b1));
    check_st("single_ret", 3'b000, 3'b000);
    eret = 1'b0;
    step(1);
    check("hold_target", target_pc, 32'h100);

    // Ignored return with nothing in service.
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("idle_eret", 32'(is_eret), 32'(1'b0));

    // Simultaneous src0 and src2: src0 first, src2 blocked until return.
    pc_in  = 32'h300;
    src_in = 3'b101;
    expect_exp(32'h800, 2'd0);
    step(2);
    check_st("simul_grant", 3'b100, 3'b001);
    step(3);
    check_st("simul_blocked", 3'b100, 3'b001);
    check("simul_no_exp", 32'(has_exp), 32'(1'b0));
    eret = 1'b1;
    expect_ret(32'h300, 2'd0);
    expect_exp(32'h820, 2'd2);
    step(1);
    eret = 1'b0;
    check_st("simul_ret", 3'b100, 3'b000);
    step(1);
    check_st("simul_src2", 3'b000, 3'b100);
    src_in = '0;
    eret   = 1'b1;
    expect_ret(32'h300, 2'd2);
    step(1);
    eret = 1'b0;
    step(1);

    // Nesting: src2 at 0x200 preempted by src1 at 0x824.
    pc_in     = 32'h200;
    src_in[2] = 1'b1;
    expect_exp(32'h820, 2'd2);
    step(2);
    check_st("nest_outer", 3'b000, 3'b100);
    pc_in     = 32'h824;
    src_in[1] = 1'b1;
    expect_exp(32'h810, 2'd1);
    step(2);
    check_st("nest_inner", 3'b000, 3'b110);
    eret = 1'b1;
    expect_ret(32'h824, 2'd1);
    step(1);
    eret = 1'b0;
    check_st("nest_ret1", 3'b000, 3'b100);
    step(1);
    eret = 1'b1;
    expect_ret(32'h200, 2'd1);
    step(1);
    eret = 1'b0;
    check_st("nest_ret2", 3'b000, 3'b000);
    src_in = '0;
    step(1);

    // Mask: disabled source stays pending until re-enabled.
    mask_we = 1'b1;
    mask_wd = 3'b110;
    step(1);
    mask_we = 1'b0;
    check("mask_write", 32'(mask), 32'(3'b110));
    src_in[0] = 1'b1;
    step(1);
    check_st("mask_pend", 3'b001, 3'b000);
    step(10);
    check_st("mask_hold", 3'b001, 3'b000);
    pc_in   = 32'h400;
    mask_we = 1'b1;
    mask_wd = 3'b111;
    expect_exp(32'h800, 2'd0);
    step(1);
    mask_we = 1'b0;
    check("unmask_no_exp_yet", 32'(has_exp), 32'(1'b0));
    step(1);
    check("unmask_has_exp", 32'(has_exp), 32'(1'b1));
    eret = 1'b1;
    expect_ret(32'h400, 2'd0);
    step(1);
    eret   = 1'b0;
    src_in = '0;
    step(1);

    // Overrun under stall, then exactly one grant.
    stall     = 1'b1;
    src_in[1] = 1'b1;
    step(1);
    src_in[1] = 1'b0;
    step(1);
    src_in[1] = 1'b1;
    step(1);
    check_st("ovr_pend", 3'b010, 3'b000);
    check("ovr_flag", 32'(overrun), 32'(3'b010));
    src_in[1] = 1'b0;
    pc_in     = 32'h500;
    stall     = 1'b0;
    expect_exp(32'h810, 2'd1);
    step(1);
    check("ovr_has_exp", 32'(has_exp), 32'(1'b1));
    step(3);
    check_st("ovr_single", 3'b000, 3'b010);
    check("ovr_sticky", 32'(overrun), 32'(3'b010));

    // Conflict: return wins, the request is granted the next cycle.
    src_in[0] = 1'b1;
    step(1);
    check_st("conf_pend", 3'b001, 3'b010);
    eret  = 1'b1;
    pc_in = 32'h600;
    expect_ret(32'h500, 2'd1);
    expect_exp(32'h800, 2'd0);
    step(1);
    eret = 1'b0;
    check("conf_is_eret", 32'({has_exp, is_eret}), 32'(2'b01));
    check_st("conf_ret", 3'b001, 3'b000);
    step(1);
    check("conf_has_exp", 32'({has_exp, is_eret}), 32'(2'b10));
    check_st("conf_grant", 3'b000, 3'b001);
    mask_we = 1'b1;
    mask_wd = 3'b010;
    step(1);
    mask_we = 1'b0;

    // Reset mid-service, with src0 still high across the release.
    rst = 1'b0;
    step(1);
    check_st("mid_rst", 3'b000, 3'b000);
    check("mid_rst_overrun", 32'(overrun), 32'(3'b000));
    check("mid_rst_mask", 32'(mask), 32'(3'b111));
    check("mid_rst_target", target_pc, 32'h0);
    check("mid_rst_pulses", 32'({has_exp, is_eret}), 32'(2'b00));
    rst   = 1'b1;
    pc_in = 32'h700;
    expect_exp(32'h800, 2'd0);
    step(1);
    check_st("rel_event", 3'b001, 3'b000);
    step(1);
    check("rel_has_exp", 32'(has_exp), 32'(1'b1));
    src_in = '0;
    step(2);

    check("sb_drain", 32'(sb.size()), 32'h0);
    check("pulse_excl", 32'(both_hi), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter NSRC, default 3: number of exception sources; index 0 is highest priority.
REQ-002 Parameter VEC_BASE, default 32'h0000_0800: base address of the handler vector table.
REQ-003 Parameter MASK_RST, default all ones: reset value of the enable mask.
REQ-004 clk  in  1  single clock; every register updates on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 src_in  in  NSRC  raw level exception sources; each rising edge is one event.
REQ-007 pc_in  in  32  current PC; captured as the return address on grant.
REQ-008 stall  in  1  while high, no new grant is issued.
REQ-009 eret  in  1  return-from-exception strobe, one cycle.
REQ-010 mask_we, mask_wd  in  1, NSRC  mask write strobe and data; mask bit 1 = source enabled.
REQ-011 has_exp  out  1  registered one-cycle pulse marking exception entry.
REQ-012 is_eret  out  1  registered one-cycle pulse marking an accepted return.
REQ-013 target_pc  out  32  redirect PC; valid while has_exp or is_eret is high.
REQ-014 cause  out  clog2(NSRC)  index of the most recently granted source.
REQ-015 pending, in_service, mask, overrun  out  NSRC each  status registers.

Function
REQ-016 Edge detect: src_q SHALL register src_in; an event is src_in & ~src_q at a clock edge, and it sets the pending bit at that edge.
REQ-017 Eligibility: a source SHALL be eligible when pending, mask and the nesting rule (REQ-018) all allow it, and stall and eret are both low.
REQ-018 Nesting: a source SHALL be eligible only if its index is strictly lower than the lowest-index in_service bit, or if in_service is 0.
REQ-019 Priority: among eligible sources the lowest index SHALL win, and at most one grant SHALL occur per cycle.
REQ-020 Grant edge: the arbiter SHALL set has_exp=1, target_pc=VEC_BASE+(idx<<4), cause=idx, set in_service[idx], clear pending[idx], and push pc_in onto the EPC stack.
REQ-021 Latency: a source rising before edge E1 sets pending at E1; has_exp SHALL be high for the cycle after E2.
REQ-022 EPC stack depth SHALL be NSRC; by construction of REQ-018 it cannot overflow.
REQ-023 Return: eret with in_service≠0 SHALL pop the EPC stack into target_pc, clear the lowest-index in_service bit, and pulse is_eret.
REQ-024 eret with in_service=0 SHALL be ignored: no pulse and no state change.
REQ-025 eret and an eligible request in the same cycle: eret SHALL win; the request stays pending and is re-arbitrated in the next cycle.
REQ-026 An event on a source whose pending bit is already set SHALL leave pending set and set the sticky overrun bit; overrun is cleared only by reset.
REQ-027 An event on the same edge that grants and clears that source's pending bit SHALL leave pending set, as a new event, with no overrun.
REQ-028 Masked or stalled requests SHALL remain pending indefinitely.
REQ-029 A mask write SHALL take effect for arbitration from the next cycle.
REQ-030 has_exp and is_eret SHALL never be high in the same cycle.
REQ-031 target_pc SHALL hold its last value when neither pulse is high.

Reset
REQ-032 While rst=0 at an edge: pending, in_service, overrun, src_q, has_exp, is_eret, cause, target_pc and the EPC stack SHALL become 0, and mask SHALL become MASK_RST.
REQ-033 Reset mid-service SHALL discard all nesting state, with no is_eret pulse.
REQ-034 A source already high when reset is released SHALL count as one event, because src_q resets to 0.

Verification (VEC_BASE=0x800, NSRC=3)
REQ-035 Single event: src1 rises with pc_in=0x100 -> has_exp after 2 edges, target_pc=0x810, cause=1, in_service=010; then eret -> is_eret, target_pc=0x100, in_service=000.
REQ-036 Simultaneous: src0 and src2 rise together -> grant 0x800 first with pending=100; src2 is not granted until after eret; first eligible cycle -> target_pc=0x820.
REQ-037 Nesting: src2 is granted at pc 0x200, then src1 at pc 0x824 -> target 0x810 with in_service=110; eret -> 0x824 with in_service=100; eret -> 0x200 with in_service=000.
REQ-038 Mask: with mask=110, src0 rises -> pending=001 and no has_exp for 10 cycles; write mask=111 -> has_exp with target 0x800 one cycle after the mask write takes effect.
REQ-039 Overrun/stall: hold stall=1 and give src1 two edges -> pending=010, overrun=010; release stall -> a single grant only.
REQ-040 Conflict/reset: eret and an src0 request in the same cycle -> is_eret now, has_exp next cycle; assert rst=0 with in_service≠0 -> all status 0 and mask=111.
